// File: rtl/trap_pkg.sv
// trap_pkg: shared CSR addresses, trap encodings, cause codes, FSM states and mstatus bit positions.
package trap_pkg;
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC = 12'h305;
  localparam logic [11:0] CSR_MEPC = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam int CAUSE_ECALL_M = 11;
  localparam int CAUSE_ILLEGAL_INSN = 2;
  localparam int MIE_BIT = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_LO = 11;
  localparam int MPP_HI = 12;
  typedef enum logic [1:0] {
    TT_NONE  = 2'b00,
    TT_ECALL = 2'b01,
    TT_UNIMP = 2'b10,
    TT_MRET  = 2'b11
  } trap_type_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE_EPC,
    S_SAVE_CAUSE,
    S_SAVE_STATUS,
    S_RESTORE,
    S_REDIRECT
  } state_e;
endpackage

// File: rtl/mstatus_update.sv
// mstatus_update: computes the mstatus value written on trap entry (is_mret_i=0) or mret (is_mret_i=1).
module mstatus_update
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus_in,
  input  logic            is_mret_i,
  output logic [XLEN-1:0] mstatus_o
);
  always_comb begin
    mstatus_o = mstatus_in;
    mstatus_o[MIE_BIT] = is_mret_i ? mstatus_in[MPIE_BIT] : 1'b0;
    mstatus_o[MPIE_BIT] = is_mret_i ? 1'b1 : mstatus_in[MIE_BIT];
    mstatus_o[MPP_HI:MPP_LO] = 2'b11;
  end
endmodule

// File: rtl/trap_sequencer.sv
// trap_sequencer: multi-cycle FSM sequencing M-mode trap entry and mret over one CSR write port.
module trap_sequencer
  import trap_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int CAUSE_ECALL = CAUSE_ECALL_M,
  parameter int CAUSE_ILLEGAL = CAUSE_ILLEGAL_INSN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [1:0]      trap_type,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic [XLEN-1:0] mstatus_in,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy
);
  state_e state_q, state_d;
  logic [1:0] type_q, type_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] mstatus_new;
  logic is_mret, accept;
  assign is_mret = type_q == TT_MRET;
  assign busy = state_q != S_IDLE;
  assign accept = state_q == S_IDLE && trap_valid && trap_type != TT_NONE;
  assign stall = busy || accept;
  mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
    .mstatus_in(mstatus_in),
    .is_mret_i (is_mret),
    .mstatus_o (mstatus_new)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      type_q <= 2'b00;
      pc_q <= '0;
    end else begin
      state_q <= state_d;
      type_q <= type_d;
      pc_q <= pc_d;
    end
  end
  always_comb begin
    state_d = S_IDLE;
    type_d = type_q;
    pc_d = pc_q;
    csr_we = 1'b0;
    csr_waddr = 12'h000;
    csr_wdata = '0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          type_d = trap_type;
          pc_d = trap_pc;
        end
        state_d = !accept ? S_IDLE : trap_type == TT_MRET ? S_RESTORE : S_SAVE_EPC;
      end
      S_SAVE_EPC: begin
        csr_we = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = {pc_q[XLEN-1:2], 2'b00};
        state_d = S_SAVE_CAUSE;
      end
      S_SAVE_CAUSE: begin
        csr_we = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = type_q == TT_ECALL ? XLEN'(CAUSE_ECALL) : XLEN'(CAUSE_ILLEGAL);
        state_d = S_SAVE_STATUS;
      end
      S_SAVE_STATUS, S_RESTORE: begin
        csr_we = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_new;
        state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = is_mret ? {mepc_in[XLEN-1:2], 2'b00} : {mtvec_in[XLEN-1:2], 2'b00};
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle FSM that sequences machine-mode trap entry (ecall, illegal/unimplemented instruction) and trap return (mret) for the CPU.
- Consumes the decoder's 2-bit trap code once the trapping instruction reaches the commit point.
- Drives the single CSR write port over successive cycles (mepc, mcause, mstatus).
- Holds the pipeline stalled, then issues one flush/redirect to mtvec or mepc.

Parameters:
XLEN, 32, datapath/CSR width
CAUSE_ECALL, 11, mcause value written for ecall (M-mode)
CAUSE_ILLEGAL, 2, mcause value written for trap code 10 (unimp/illegal)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
trap_valid  in  1  trapping instruction present at commit this cycle
trap_type  in  2  00 none, 01 ecall, 10 unimp, 11 mret (decoder encoding)
trap_pc  in  XLEN  PC of the trapping instruction
mtvec_in  in  XLEN  current mtvec CSR value
mepc_in  in  XLEN  current mepc CSR value
mstatus_in  in  XLEN  current mstatus CSR value
csr_we  out  1  CSR write enable
csr_waddr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
stall  out  1  freeze fetch/decode/execute
flush  out  1  kill all younger in-flight instructions
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  XLEN  new PC
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchronous and active-high on rst; clock is clk. On the edge with rst=1: state=IDLE, latched type/pc cleared. All outputs 0 while in IDLE with trap_valid=0.
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, RESTORE, REDIRECT.
- Acceptance: in IDLE, trap_valid=1 with trap_type!=00 latches trap_type and trap_pc. Next state is SAVE_EPC for types 01/10 and RESTORE for type 11.
- Ignored inputs: trap_valid=1 with trap_type=00 is ignored. trap_valid while not IDLE is ignored; the pipeline is stalled, so it must not recur.
- stall = busy OR (state==IDLE AND trap_valid AND trap_type!=00). Combinational, so the acceptance cycle is already stalled.
- SAVE_EPC (1 cycle): csr_we=1, addr 0x341, data = latched pc with bits[1:0] cleared.
- SAVE_CAUSE (1 cycle): csr_we=1, addr 0x342, data = CAUSE_ECALL (type 01) or CAUSE_ILLEGAL (type 10), zero-extended.
- SAVE_STATUS (1 cycle): csr_we=1, addr 0x300. Data = mstatus_in with bit7 (MPIE) set to mstatus_in bit3 (MIE), bit3 cleared, and bits[12:11] (MPP) set to 2'b11. All other bits pass through.
- RESTORE (1 cycle): csr_we=1, addr 0x300. Data = mstatus_in with bit3 set to mstatus_in bit7, bit7 set to 1, and MPP set to 2'b11.
- REDIRECT (1 cycle): redirect_valid=1, flush=1, csr_we=0. redirect_pc = mtvec_in with bits[1:0] cleared (entry) or mepc_in with bits[1:0] cleared (mret). The source CSR is sampled combinationally in this cycle, so a write made in an earlier state is already visible. Next state is IDLE.
- Latency, with acceptance at edge N: entry drives CSR writes in cycles N+1..N+3 and redirects in N+4. mret restores in N+1 and redirects in N+2. Back in IDLE at N+5 / N+3; a new trap is accepted in that cycle.
- Output gating: csr_we, flush and redirect_valid are asserted only in the states listed above, never in IDLE.
- Reset mid-sequence: return to IDLE on that edge. No further CSR writes, no redirect. Partially written CSRs are not rolled back.
- Unused encodings: an illegal state encoding returns to IDLE on the next edge.

Decomposition:
- Shared package trap_pkg: CSR address constants (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342), trap_type encodings, cause codes, state enum, mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
- One combinational sub-module, mstatus_update (inputs mstatus_in and an is_mret flag, output new mstatus). It is shared by SAVE_STATUS and RESTORE; the FSM stays in trap_sequencer.

Test Plan:
- Ecall with trap_pc=0x0000_0104, mstatus_in=0x0000_0008, mtvec_in=0x0000_0201 → writes (0x341,0x104), (0x342,11), (0x300,0x0000_1880) in consecutive cycles. Then redirect_pc=0x200 with flush=1 for one cycle; stall high from acceptance through REDIRECT.
- Unimp (type 10) with trap_pc=0x0000_0040 → mcause write of 2. Redirect 4 cycles after acceptance; busy=0 on the 5th.
- Mret with mstatus_in=0x0000_1880, mepc_in=0x0000_0108 → single write (0x300,0x0000_1888). Then redirect_pc=0x108 one cycle later; no writes to 0x341/0x342.
- trap_valid=1 with type 00, and trap_valid pulses while busy → no state change, no extra CSR writes, stall unaffected by the ignored requests.
- rst asserted during SAVE_CAUSE → next cycle IDLE, all outputs 0, no redirect. A fresh ecall afterwards completes the full 4-cycle sequence.
- Back-to-back: ecall accepted in the first IDLE cycle after a mret completes → correct sequence with no dropped or duplicated CSR write.
